serial_adder_ctrl: RTL and testbench

- Bit-serial adder controller that drives the team's 3-input/2-output full-adder cell: A, B, carry-in in; D = sum, E = carry-out.
- Accepts two WIDTH-bit operands and feeds them to the cell LSB-first, one bit per clock.
- Registers the cell's carry-out back into carry-in on the next clock.
- Collects the sum bits into a WIDTH-bit result and reports the final carry.
- Is the sequencing stage directly upstream and downstream of the cell: it drives A/B/C and consumes D/E.

---
 rtl/serial_adder_ctrl.sv | 104 ++++++++++
 tb/tb_serial_adder_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial add sequencer for the full-adder cell.
// Feeds operands LSB-first, recirculates carry, collects the sum.
module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             fa_a,
   output logic             fa_b,
   output logic             fa_cin,
   input  logic             fa_sum,
   input  logic             fa_cout,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum_out,
   output logic             cout
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] sum_sr;
   logic [WIDTH-1:0] sum_nx;
   logic             carry_q;
   logic [CW-1:0]    cnt;
   logic             last;
   logic             in_shift;

   assign in_shift = (state_q == SHIFT);
   assign last     = (cnt == CW'(WIDTH - 1));
   assign sum_nx   = {fa_sum, sum_sr[WIDTH-1:1]};

   assign busy   = in_shift;
   assign done   = (state_q == DONE);
   assign fa_a   = in_shift & a_sr[0];
   assign fa_b   = in_shift & b_sr[0];
   assign fa_cin = in_shift & carry_q;

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state: accept in IDLE, run WIDTH bits, one-cycle DONE
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = SHIFT;
         SHIFT:   if (last) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // operand/sum shifting, carry recirculation and result capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr    <= '0;
         b_sr    <= '0;
         sum_sr  <= '0;
         carry_q <= 1'b0;
         cnt     <= '0;
         sum_out <= '0;
         cout    <= 1'b0;
      end else if (state_q == IDLE) begin
         if (start) begin
            a_sr    <= a_in;
            b_sr    <= b_in;
            sum_sr  <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
         end
      end else if (in_shift) begin
         a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
         b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
         sum_sr  <= sum_nx;
         carry_q <= fa_cout;
         if (last) begin
            cnt     <= '0;
            sum_out <= sum_nx;
            cout    <= fa_cout;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed + random bench with attached adder cell.
// Expected sums are queued at start and checked at done.
module tb_serial_adder_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a_in = '0;
   logic [W-1:0] b_in = '0;
   logic         fa_a;
   logic         fa_b;
   logic         fa_cin;
   logic         fa_sum;
   logic         fa_cout;
   logic         busy;
   logic         done;
   logic [W-1:0] sum_out;
   logic         cout;

   int tests = 0;
   int fails = 0;

   logic [W:0] sb[$];
   logic [W:0] expv;

   always #5 clk = ~clk;

   assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
   assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .a_in    (a_in),
      .b_in    (b_in),
      .fa_a    (fa_a),
      .fa_b    (fa_b),
      .fa_cin  (fa_cin),
      .fa_sum  (fa_sum),
      .fa_cout (fa_cout),
      .busy    (busy),
      .done    (done),
      .sum_out (sum_out),
      .cout    (cout)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
      start = 1'b1;
      a_in  = a;
      b_in  = b;
      sb.push_back({1'b0, a} + {1'b0, b});
      @(negedge clk);
      start = 1'b0;
      a_in  = W'($urandom);
      b_in  = W'($urandom);
   endtask

   task automatic wait_result(input string tag);
      bit seen = 0;
      for (int i = 0; i < 4 * W; i++) begin
         if (done) begin
            seen = 1;
            break;
         end
         @(negedge clk);
      end
      if (!seen || sb.size() == 0) begin
         chk({tag, "_timeout"}, 32'(seen), 32'd1);
      end else begin
         expv = sb.pop_front();
         chk(tag, 32'({cout, sum_out}), 32'(expv));
      end
   endtask

   initial begin
      logic [W-1:0] cin_seq;
      int           busy_cnt;
      bit           saw_done;

      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_sum", 32'(sum_out), 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
      chk("rst_fa", 32'({fa_a, fa_b, fa_cin}), 32'd0);

      start_op(8'h05, 8'h03);
      cin_seq  = '0;
      busy_cnt = 0;
      for (int k = 0; k < W; k++) begin
         busy_cnt += int'(busy);
         cin_seq[k] = fa_cin;
         @(negedge clk);
      end
      chk("basic_busy_cycles", 32'(busy_cnt), 32'd8);
      chk("basic_cin_seq", 32'(cin_seq), 32'h0E);
      chk("basic_done_cyc9", 32'(done), 32'd1);
      wait_result("basic_sum");
      @(negedge clk);
      chk("basic_done_width", 32'(done), 32'd0);

      start_op(8'hFF, 8'h01);
      wait_result("ovf_ff_01");
      @(negedge clk);
      chk("ovf_done_width", 32'(done), 32'd0);
      start_op(8'hFF, 8'hFF);
      wait_result("ovf_ff_ff");
      @(negedge clk);
      repeat (3) @(negedge clk);
      chk("hold_idle", 32'({cout, sum_out}), 32'h1FE);

      start_op(8'h12, 8'h34);
      chk("hold_on_start", 32'({cout, sum_out}), 32'h1FE);
      @(negedge clk);
      start = 1'b1;
      a_in  = 8'hAA;
      @(negedge clk);
      start = 1'b0;
      wait_result("ign_start");
      start = 1'b1;
      a_in  = 8'h01;
      b_in  = 8'h02;
      sb.push_back(9'h003);
      @(negedge clk);
      chk("held_idle_gap_busy", 32'(busy), 32'd0);
      chk("held_idle_gap_done", 32'(done), 32'd0);
      @(negedge clk);
      chk("held_accept", 32'(busy), 32'd1);
      start = 1'b0;
      wait_result("held_sum");
      @(negedge clk);

      start_op(8'h7F, 8'h80);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_done", 32'(done), 32'd0);
      chk("arst_sum", 32'(sum_out), 32'd0);
      chk("arst_cout", 32'(cout), 32'd0);
      chk("arst_fa", 32'({fa_a, fa_b, fa_cin}), 32'd0);
      sb.delete();
      repeat (2) @(negedge clk);
      rst_n    = 1'b1;
      saw_done = 0;
      for (int i = 0; i < 2 * W; i++) begin
         @(negedge clk);
         if (done) saw_done = 1;
      end
      chk("arst_no_done", 32'(saw_done), 32'd0);

      for (int n = 0; n < 2000; n++) begin
         start_op(W'($urandom), W'($urandom));
         wait_result("rand_sum");
         @(negedge clk);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
